mii_tx_scheduler: RTL and testbench

Round-robin scheduler that shares one MII transmit generator between N_REQ frame sources.
- Grants one source at a time.
- Sequences tx_en/valid for the granted frame length in 64-bit words.
- Flags the last word as mac_done.
- Enforces a programmable inter-packet gap.
- Sits between the MAC-side request logic and the MII generator's i_mii_tx_en / i_valid / i_mac_done inputs.

---
 rtl/mii_tx_scheduler.sv | 232 +++++++++++++++++++++++
 tb/tb_mii_tx_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mii_tx_scheduler.sv
// mii_tx_scheduler
//   Round-robin arbiter that shares one MII transmit generator between
//   N_REQ frame sources. One source is granted at a time. For the granted
//   frame it sequences tx_en/valid word by word, flags the last word with
//   mac_done, and then holds off for IPG_CYCLES idle cycles. Every output
//   is registered.
//
// Ports
//   clk          rising-edge clock
//   i_rst_n      synchronous active-low reset
//   i_req        level request per source
//   i_len        per-source frame length in 64-bit words, source k at [k*LEN_WIDTH +: LEN_WIDTH]
//   i_pause      backpressure, suppresses o_valid one cycle later
//   o_grant      one-hot grant
//   o_sel        index of the granted source
//   o_mii_tx_en  generator tx enable
//   o_valid      generator word valid
//   o_mac_done   high on the last valid word of the frame
//   o_word_cnt   index of the current word within the frame
//   o_busy       high while in TX or IPG
//   o_err_len    one-cycle pulse when a granted length is rejected
//   o_frame_cnt  completed-frame counter, wraps silently
//
// State table
//   S_IDLE | waiting for requests, arbitrates every cycle
//   S_TX   | streaming the granted frame, one word per valid cycle
//   S_IPG  | inter-packet gap, busy without tx_en
module mii_tx_scheduler #(
    parameter int N_REQ           = 4,
    parameter int LEN_WIDTH       = 11,
    parameter int MAX_FRAME_WORDS = 190,
    parameter int IPG_CYCLES      = 2
) (
    input  logic                       clk,
    input  logic                       i_rst_n,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [N_REQ*LEN_WIDTH-1:0] i_len,
    input  logic                       i_pause,
    output logic [N_REQ-1:0]           o_grant,
    output logic [2:0]                 o_sel,
    output logic                       o_mii_tx_en,
    output logic                       o_valid,
    output logic                       o_mac_done,
    output logic [LEN_WIDTH-1:0]       o_word_cnt,
    output logic                       o_busy,
    output logic                       o_err_len,
    output logic [15:0]                o_frame_cnt
);

    localparam int PTR_W = (N_REQ < 2) ? 1 : $clog2(N_REQ);
    localparam int IPG_W = (IPG_CYCLES < 2) ? 1 : $clog2(IPG_CYCLES + 1);
    localparam logic [IPG_W-1:0] IPG_LOAD =
        (IPG_CYCLES > 0) ? IPG_W'(IPG_CYCLES - 1) : '0;
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TX   = 2'd1,
        S_IPG  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [IPG_W-1:0]     ipg_q, ipg_d;

    logic [N_REQ-1:0]     grant_q, grant_d;
    logic [2:0]           sel_q, sel_d;
    logic                 tx_en_q, tx_en_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic [LEN_WIDTH-1:0] wc_q, wc_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic [15:0]          frame_cnt_q;
    logic                 frame_inc;

    logic                 found;
    logic [PTR_W-1:0]     winner;
    logic [LEN_WIDTH-1:0] win_len;
    logic                 len_ok;

    // Round-robin search: first requester at or after ptr, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && i_req[idx]) begin
                found  = 1'b1;
                winner = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        win_len = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (PTR_W'(k) == winner) win_len = i_len[k*LEN_WIDTH +: LEN_WIDTH];
        end
        len_ok = (win_len != '0) && (win_len <= LEN_WIDTH'(MAX_FRAME_WORDS));
    end

    // State register plus all registered outputs.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            len_q   <= '0;
            ipg_q   <= '0;
            grant_q <= '0;
            sel_q   <= '0;
            tx_en_q <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            wc_q    <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            ipg_q   <= ipg_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            tx_en_q <= tx_en_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            wc_q    <= wc_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Kept in its own process and only written on reset or increment.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            frame_cnt_q <= '0;
        end else if (frame_inc) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    // Next-state logic. done_q marks the last word currently on the bus.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (found && len_ok) state_d = S_TX;
            end
            S_TX: begin
                if (done_q) state_d = (IPG_CYCLES == 0) ? S_IDLE : S_IPG;
            end
            S_IPG: begin
                if (ipg_q == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        ptr_d     = ptr_q;
        len_d     = len_q;
        ipg_d     = ipg_q;
        grant_d   = '0;
        sel_d     = '0;
        tx_en_d   = 1'b0;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        wc_d      = '0;
        busy_d    = 1'b0;
        err_d     = 1'b0;
        frame_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    ptr_d   = (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + PTR_W'(1);
                    grant_d = ONE_HOT0 << winner;
                    sel_d   = 3'(winner);
                    if (len_ok) begin
                        len_d   = win_len;
                        tx_en_d = 1'b1;
                        busy_d  = 1'b1;
                        valid_d = ~i_pause;
                        done_d  = ~i_pause && (win_len == LEN_WIDTH'(1));
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_TX: begin
                if (done_q) begin
                    frame_inc = 1'b1;
                    if (IPG_CYCLES > 0) begin
                        busy_d = 1'b1;
                        ipg_d  = IPG_LOAD;
                    end
                end else begin
                    grant_d = grant_q;
                    sel_d   = sel_q;
                    tx_en_d = 1'b1;
                    busy_d  = 1'b1;
                    // The word on the bus this cycle only counts if it was valid.
                    wc_d    = wc_q + LEN_WIDTH'(valid_q);
                    valid_d = ~i_pause;
                    done_d  = ~i_pause && (wc_d == len_q - LEN_WIDTH'(1));
                end
            end
            S_IPG: begin
                busy_d = (ipg_q != '0);
                if (ipg_q != '0) ipg_d = ipg_q - IPG_W'(1);
            end
            default: begin
                ptr_d = '0;
            end
        endcase
    end

    assign o_grant     = grant_q;
    assign o_sel       = sel_q;
    assign o_mii_tx_en = tx_en_q;
    assign o_valid     = valid_q;
    assign o_mac_done  = done_q;
    assign o_word_cnt  = wc_q;
    assign o_busy      = busy_q;
    assign o_err_len   = err_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_mii_tx_scheduler.sv
// Testbench for mii_tx_scheduler: directed steps plus random traffic checked
// cycle by cycle against a frame-level reference model, and a second build
// with a zero inter-packet gap for back-to-back and counter-wrap behaviour.
module tb_mii_tx_scheduler;

    localparam int N    = 4;
    localparam int LW   = 11;
    localparam int MAXW = 190;
    localparam int G    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, pause;
    logic [N-1:0]    req;
    logic [N*LW-1:0] len;
    logic [N-1:0]    grant;
    logic [2:0]      sel;
    logic            tx_en, valid, done, busy, err;
    logic [LW-1:0]   wc;
    logic [15:0]     fcnt;

    logic            rst1_n, pause1;
    logic [N-1:0]    req1;
    logic [N*LW-1:0] len1;
    logic [N-1:0]    grant1;
    logic [2:0]      sel1;
    logic            tx_en1, valid1, done1, busy1, err1;
    logic [LW-1:0]   wc1;
    logic [15:0]     fcnt1;

    mii_tx_scheduler #(.N_REQ(N), .LEN_WIDTH(LW), .MAX_FRAME_WORDS(MAXW), .IPG_CYCLES(G)) dut (
        .clk(clk), .i_rst_n(rst_n), .i_req(req), .i_len(len), .i_pause(pause),
        .o_grant(grant), .o_sel(sel), .o_mii_tx_en(tx_en), .o_valid(valid),
        .o_mac_done(done), .o_word_cnt(wc), .o_busy(busy), .o_err_len(err),
        .o_frame_cnt(fcnt)
    );

    mii_tx_scheduler #(.N_REQ(N), .LEN_WIDTH(LW), .MAX_FRAME_WORDS(MAXW), .IPG_CYCLES(0)) dut1 (
        .clk(clk), .i_rst_n(rst1_n), .i_req(req1), .i_len(len1), .i_pause(pause1),
        .o_grant(grant1), .o_sel(sel1), .o_mii_tx_en(tx_en1), .o_valid(valid1),
        .o_mac_done(done1), .o_word_cnt(wc1), .o_busy(busy1), .o_err_len(err1),
        .o_frame_cnt(fcnt1)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: where we are in the current frame, described by
    // words already delivered and gap cycles still owed.
    int lens[N];
    int m_phase;    // 0 waiting, 1 sending, 2 gap
    int m_ptr, m_len, m_sent, m_gap, m_frames;
    int e_grant, e_sel, e_tx, e_valid, e_done, e_busy, e_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_lens();
        for (int k = 0; k < N; k++) len[k*LW +: LW] = LW'(lens[k]);
    endtask

    task automatic clear_expect();
        e_grant = 0; e_sel = 0; e_tx = 0; e_valid = 0;
        e_done = 0; e_busy = 0; e_err = 0; m_sent = 0;
    endtask

    task automatic model_step(input logic r, input logic [N-1:0] q, input logic p);
        int w;
        if (!r) begin
            m_phase = 0; m_ptr = 0; m_frames = 0;
            clear_expect();
            return;
        end
        case (m_phase)
            0: begin
                clear_expect();
                if (q != 0) begin
                    w = -1;
                    for (int k = 0; k < N; k++)
                        if (w < 0 && q[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                    m_ptr   = (w + 1) % N;
                    e_grant = 1 << w;
                    e_sel   = w;
                    if (lens[w] >= 1 && lens[w] <= MAXW) begin
                        m_phase = 1; m_len = lens[w];
                        e_tx = 1; e_busy = 1;
                        e_valid = p ? 0 : 1;
                        e_done  = (e_valid == 1 && m_len == 1) ? 1 : 0;
                    end else begin
                        e_err = 1;
                    end
                end
            end
            1: begin
                if (e_done == 1) begin
                    m_frames = (m_frames + 1) % 65536;
                    clear_expect();
                    if (G > 0) begin m_phase = 2; m_gap = G; e_busy = 1; end
                    else m_phase = 0;
                end else begin
                    if (e_valid == 1) m_sent++;
                    e_valid = p ? 0 : 1;
                    e_done  = (e_valid == 1 && m_sent == m_len - 1) ? 1 : 0;
                end
            end
            default: begin
                m_gap--;
                if (m_gap == 0) begin m_phase = 0; e_busy = 0; end
            end
        endcase
    endtask

    task automatic check_all();
        check("grant",     32'(grant), e_grant);
        check("sel",       32'(sel),   e_sel);
        check("tx_en",     32'(tx_en), e_tx);
        check("valid",     32'(valid), e_valid);
        check("mac_done",  32'(done),  e_done);
        check("word_cnt",  32'(wc),    m_sent);
        check("busy",      32'(busy),  e_busy);
        check("err_len",   32'(err),   e_err);
        check("frame_cnt", 32'(fcnt),  m_frames);
    endtask

    task automatic tick();
        logic r, p;
        logic [N-1:0] q;
        r = rst_n; q = req; p = pause;
        @(posedge clk);
        #1;
        model_step(r, q, p);
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [15:0] exp_cnt;
        m_phase = 0; m_ptr = 0; m_frames = 0; m_len = 0; m_gap = 0;
        clear_expect();
        rst_n = 1'b0; req = '0; pause = 1'b0;
        for (int k = 0; k < N; k++) lens[k] = 1;
        apply_lens();
        rst1_n = 1'b0; req1 = '0; pause1 = 1'b0;
        for (int k = 0; k < N; k++) len1[k*LW +: LW] = LW'(1);

        // Reset state
        ticks(2);
        rst_n = 1'b1;

        // Single 4-word frame from source 0
        lens[0] = 4; apply_lens();
        req = 4'b0001; tick();
        req = 4'b0000; ticks(8);
        check("frame_cnt_after_first", 32'(fcnt), 1);

        // Two sources alternating, fresh pointer
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        lens[0] = 2; lens[1] = 2; apply_lens();
        req = 4'b0011; ticks(22);
        req = 4'b0000; ticks(6);

        // Pause in the middle of a frame
        lens[0] = 5; apply_lens();
        req = 4'b0001; tick();
        req = 4'b0000; ticks(2);
        pause = 1'b1; ticks(3);
        pause = 1'b0; ticks(10);

        // Length boundaries: 0 rejected, 190 accepted, 191 rejected
        lens[0] = 0; apply_lens();
        req = 4'b0001; tick();
        req = 4'b0000; ticks(3);
        lens[0] = 190; apply_lens();
        req = 4'b0001; tick();
        req = 4'b0000; ticks(196);
        lens[0] = 191; apply_lens();
        req = 4'b0001; tick();
        req = 4'b0000; ticks(3);

        // Reset mid-frame, then source 0 wins after the pointer clears
        lens[1] = 6; apply_lens();
        req = 4'b0010; tick();
        req = 4'b0000; ticks(3);
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        lens[0] = 2; lens[2] = 2; apply_lens();
        req = 4'b0101; tick();
        check("rst_prio_sel", 32'(sel), 0);
        req = 4'b0000; ticks(6);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            int r;
            rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            req   = N'($urandom_range(0, 15));
            pause = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) begin
                r = $urandom_range(0, 19);
                lens[$urandom_range(0, N-1)] = (r == 0) ? 0 : (r == 1) ? 191 :
                                               (r == 2) ? 190 : $urandom_range(1, 6);
                apply_lens();
            end
            tick();
        end
        req = '0; pause = 1'b0; rst_n = 1'b1;
        ticks(2);

        // Zero-gap build: len=1 back to back
        @(negedge clk);
        @(negedge clk);
        rst1_n = 1'b1; req1 = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("ipg0_tx_en",    32'(tx_en1), (i % 2 == 0) ? 1 : 0);
            check("ipg0_mac_done", 32'(done1),  (i % 2 == 0) ? 1 : 0);
            check("ipg0_frame_cnt", 32'(fcnt1), (i + 1) / 2);
        end
        req1 = '0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        force dut1.frame_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut1.frame_cnt_q;
        req1 = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            exp_cnt = 16'hFFFE + 16'((i + 1) / 2);
            check("wrap_frame_cnt", 32'(fcnt1), 32'(exp_cnt));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
